game_score_display: RTL

//  Shows the game score on the board's multiplexed 7-segment display.
//  It consumes the 16-bit target_count produced by the game top and tracks the best score seen.
//  The selected value is converted to BCD by a sequential double-dabble engine.

---
 rtl/game_score_pkg.sv | 32 +++
 rtl/game_bin2bcd.sv | 92 +++++++++
 rtl/game_score_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/game_score_pkg.sv
// Shared types and helpers for the score display: converter states and the
// active-high 7-segment decoder used before output polarity is applied.
package game_score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  // Segment order is {a,b,c,d,e,f,g}, 1 = lit.
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b111_1110;
      4'd1:    seg = 7'b011_0000;
      4'd2:    seg = 7'b110_1101;
      4'd3:    seg = 7'b111_1001;
      4'd4:    seg = 7'b011_0011;
      4'd5:    seg = 7'b101_1011;
      4'd6:    seg = 7'b101_1111;
      4'd7:    seg = 7'b111_0000;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b111_1011;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/game_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle for
// W_COUNT cycles, then a single LATCH cycle where bcd is valid and done pulses.
module game_bin2bcd
  import game_score_pkg::*;
#(
  parameter int W_COUNT = 16,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W_COUNT-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(W_COUNT + 1);

  conv_state_t        state_reg, state_next;
  logic [W_COUNT-1:0] bin_reg, bin_next;
  logic [BCD_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic [BCD_W-1:0]   adjusted;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      assign adjusted[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                   acc_reg[4*gi +: 4] + 4'd3 :
                                   acc_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          bin_next   = bin;
          acc_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Carry out of the top nibble falls off the left end; the input is
        // saturated upstream so it is always zero.
        {acc_next, bin_next} = {adjusted, bin_reg} << 1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(W_COUNT - 1)) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  assign busy = busy_reg;
  assign done = (state_reg == LATCH);
  assign bcd  = acc_reg;

endmodule

// File: rtl/game_score_display.sv
// Score display top: best-score tracker, saturating change detector feeding the
// BCD converter, and a prescaled digit scanner with leading-zero blanking.
module game_score_display
  import game_score_pkg::*;
#(
  parameter int W_COUNT        = 16,
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV_WIDTH = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_COUNT-1:0] target_count,
  input  logic               show_best,
  output logic [7:0]         abcdefgh,
  output logic [DIGITS-1:0]  digit,
  output logic               new_record,
  output logic               busy
);

  localparam int                BCD_W     = 4 * DIGITS;
  localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam longint unsigned   MAX_DISP  = (64'd10 ** DIGITS) - 64'd1;
  localparam logic [7:0]        SEG_OFF   = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIGIT_OFF = {DIGITS{SEG_ACTIVE_LOW}};

  logic [W_COUNT-1:0]        best_reg;
  logic                      new_record_reg;
  logic [W_COUNT-1:0]        last_value_reg;
  logic [BCD_W-1:0]          display_reg;
  logic [SCAN_DIV_WIDTH-1:0] prescaler_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [7:0]                seg_out_reg;
  logic [DIGITS-1:0]         digit_out_reg;

  logic [W_COUNT-1:0] sel;
  logic [W_COUNT-1:0] sat_sel;
  logic               start;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic [6:0]         digit_seg [DIGITS];

  always_comb begin
    sel     = show_best ? best_reg : target_count;
    sat_sel = (64'(sel) > MAX_DISP) ? W_COUNT'(MAX_DISP) : sel;
  end

  // A new conversion is launched only from IDLE; a change seen while busy is
  // retried automatically because last_value still holds the old value.
  assign start = (sat_sel != last_value_reg) && !conv_busy;

  game_bin2bcd #(
    .W_COUNT (W_COUNT),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (sat_sel),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      best_reg       <= '0;
      new_record_reg <= 1'b0;
      last_value_reg <= '0;
      display_reg    <= '0;
    end else begin
      new_record_reg <= 1'b0;
      if (target_count > best_reg) begin
        best_reg       <= target_count;
        new_record_reg <= 1'b1;
      end
      if (start) begin
        last_value_reg <= sat_sel;
      end
      if (conv_done) begin
        display_reg <= conv_bcd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler_reg <= '0;
      idx_reg       <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + SCAN_DIV_WIDTH'(1);
      if (prescaler_reg == {SCAN_DIV_WIDTH{1'b1}}) begin
        idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end
    end
  end

  // Digit 0 is never blanked so a zero score still reads "0".
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] code;
      logic       blank;
      assign code = display_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign blank = 1'b0;
      end else begin : g_upper
        assign blank = ~|display_reg[BCD_W-1:4*gi];
      end
      assign digit_seg[gi] = blank ? SEG_BLANK : seg7_decode(code);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_out_reg   <= SEG_OFF;
      digit_out_reg <= DIGIT_OFF;
    end else begin
      seg_out_reg   <= {digit_seg[idx_reg], 1'b0} ^ SEG_OFF;
      digit_out_reg <= (DIGITS'(1) << idx_reg) ^ DIGIT_OFF;
    end
  end

  assign abcdefgh   = seg_out_reg;
  assign digit      = digit_out_reg;
  assign new_record = new_record_reg;
  assign busy       = conv_busy;

endmodule
